// File: rtl/reg_data_selector_if.sv
// Bundle of the request (in_*) and delivery (out_*) channels of reg_data_selector.
// Both sides use valid/ready. A transfer happens on a rising clock edge when valid
// and ready are both high. The producer holds valid and its payload until then.
// in_ready depends only on buffer state, never on out_ready.
interface reg_data_selector_if #(
  parameter int WIDTH     = 4,
  parameter int CHANNELS  = 4,
  parameter int SEL_WIDTH = 2
);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [SEL_WIDTH-1:0]      in_sel;
  logic                      in_zero;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          out_y;
  logic [SEL_WIDTH-1:0]      out_ch;
  logic                      out_err;
  logic                      out_valid;
  logic                      out_ready;
  logic [1:0]                out_count;

  modport slave (
    input  in_data, in_sel, in_zero, in_valid, out_ready,
    output in_ready, out_y, out_ch, out_err, out_valid, out_count
  );

  modport master (
    output in_data, in_sel, in_zero, in_valid, out_ready,
    input  in_ready, out_y, out_ch, out_err, out_valid, out_count
  );
endinterface

// File: rtl/reg_data_selector.sv
// Registered channel selector feeding a 2-entry FIFO. Each entry carries the selected
// word, its select tag, and an out-of-range flag.
module reg_data_selector #(
  parameter int WIDTH     = 4,
  parameter int CHANNELS  = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  reg_data_selector_if.slave  io_bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_head_data;
  logic [WIDTH-1:0]     r_tail_data;
  logic [SEL_WIDTH-1:0] r_head_ch;
  logic [SEL_WIDTH-1:0] r_tail_ch;
  logic                 r_head_err;
  logic                 r_tail_err;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_in_range;
  logic [WIDTH-1:0]     w_chan;
  logic [WIDTH-1:0]     w_new_data;
  logic                 w_new_err;

  // Explicit mux avoids indexing past the packed bus for unpopulated selects.
  always_comb begin
    w_chan = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(io_bus.in_sel) == k) w_chan = io_bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  assign w_in_range = int'(io_bus.in_sel) < CHANNELS;
  assign w_new_data = (io_bus.in_zero || !w_in_range) ? '0 : w_chan;
  assign w_new_err  = !io_bus.in_zero && !w_in_range;

  assign io_bus.in_ready  = !i_rst && (r_state != ST_FULL);
  assign io_bus.out_valid = (r_state != ST_EMPTY);
  assign w_push = io_bus.in_valid && io_bus.in_ready;
  assign w_pop  = io_bus.out_valid && io_bus.out_ready;

  // Head registers are cleared whenever the buffer drains, so they drive the outputs directly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_EMPTY;
      r_head_data <= '0;
      r_head_ch   <= '0;
      r_head_err  <= 1'b0;
      r_tail_data <= '0;
      r_tail_ch   <= '0;
      r_tail_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            r_head_data <= w_new_data;
            r_head_ch   <= io_bus.in_sel;
            r_head_err  <= w_new_err;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            r_head_data <= w_new_data;
            r_head_ch   <= io_bus.in_sel;
            r_head_err  <= w_new_err;
          end else if (w_push) begin
            r_tail_data <= w_new_data;
            r_tail_ch   <= io_bus.in_sel;
            r_tail_err  <= w_new_err;
            r_state     <= ST_FULL;
          end else if (w_pop) begin
            r_head_data <= '0;
            r_head_ch   <= '0;
            r_head_err  <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_head_data <= r_tail_data;
            r_head_ch   <= r_tail_ch;
            r_head_err  <= r_tail_err;
            r_state     <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign io_bus.out_y     = r_head_data;
  assign io_bus.out_ch    = r_head_ch;
  assign io_bus.out_err   = r_head_err;
  assign io_bus.out_count = r_state;
  assign o_dbg_state      = r_state;

endmodule
